// File: rtl/uart_frame_mux_pkg.sv
// Shared definitions for the inter-board game link.
// Holds the default frame start byte, the frame-length helper and the
// transmit FSM state encoding. The receive-side demultiplexer imports the
// same package, so any format change lands in both directions at once.
package uart_frame_mux_pkg;

    localparam logic [7:0] SYNC_DEFAULT = 8'hA5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    // Bytes per frame: sync, sequence, two bytes per channel, checksum.
    function automatic int frame_len(input int nch);
        return 3 + 2 * nch;
    endfunction

endpackage

// File: rtl/uart_frame_mux_if.sv
// Bundle between the frame serializer and its host / byte transmitter.
// Ports:
//   data_in    NCH*DW channel snapshot source, channel k at [k*DW +: DW]
//   start      single-cycle frame request
//   continuous automatic back-to-back framing
//   tx_ready   byte transmitter can accept
//   tx_valid   tx_byte is valid
//   tx_byte    byte offered to the transmitter
//   busy       frame in progress or in inter-frame gap
//   seq        sequence number of the next frame
//   overrun    sticky dropped-request flag
// Modports: slave = serializer side, master = host/transmitter side.
interface uart_frame_mux_if #(
    parameter int NCH = 4,
    parameter int DW  = 12
);
    logic [NCH*DW-1:0] data_in;
    logic              start;
    logic              continuous;
    logic              tx_ready;
    logic              tx_valid;
    logic [7:0]        tx_byte;
    logic              busy;
    logic [7:0]        seq;
    logic              overrun;

    modport slave (
        input  data_in, start, continuous, tx_ready,
        output tx_valid, tx_byte, busy, seq, overrun
    );

    modport master (
        output data_in, start, continuous, tx_ready,
        input  tx_valid, tx_byte, busy, seq, overrun
    );
endinterface

// File: rtl/uart_frame_mux_frame_checksum.sv
// frame_checksum: 8-bit additive accumulator (sum mod 256).
// Ports:
//   clk, rst  clock and asynchronous active-high reset
//   clear     synchronous clear to zero (has priority over add_en)
//   add_en    add add_byte into the running sum this cycle
//   add_byte  byte to accumulate
//   sum       running sum
module frame_checksum (
    input  logic       clk,
    input  logic       rst,
    input  logic       clear,
    input  logic       add_en,
    input  logic [7:0] add_byte,
    output logic [7:0] sum
);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum <= 8'd0;
        end else if (clear) begin
            sum <= 8'd0;
        end else if (add_en) begin
            sum <= sum + add_byte;
        end
    end
endmodule

// File: rtl/uart_frame_mux.sv
// uart_frame_mux: snapshots NCH channels of DW bits and emits one framed
// packet (SYNC, seq, hi/lo byte per channel, additive checksum) to a
// byte-level UART transmitter over a valid/ready handshake.
// Ports:
//   clk   system clock, rising edge
//   rst   asynchronous active-high reset
//   link  uart_frame_mux_if.slave bundle (data, requests, tx handshake, status)
// Parameters: NCH channels, DW bits per channel, SYNC start byte,
// GAP idle cycles forced after each frame.
module uart_frame_mux
    import uart_frame_mux_pkg::*;
#(
    parameter int         NCH  = 4,
    parameter int         DW   = 12,
    parameter logic [7:0] SYNC = SYNC_DEFAULT,
    parameter int         GAP  = 0
) (
    input logic clk,
    input logic rst,
    uart_frame_mux_if.slave link
);
    localparam int FL = frame_len(NCH);
    localparam int IW = $clog2(FL);
    localparam int PW = $clog2(2 * NCH);

    typedef logic [IW-1:0] idx_t;
    localparam idx_t       LAST_IDX = idx_t'(FL - 1);
    localparam logic [7:0] GAP_LAST = 8'(GAP - 1);

    state_t            state_reg, state_next;
    idx_t              idx_reg, idx_next;
    logic [7:0]        gap_reg, gap_next;
    logic [7:0]        seq_reg, seq_next;
    logic [NCH*DW-1:0] snap_reg, snap_next;
    logic              pending_reg, pending_next;
    logic              overrun_reg, overrun_next;

    logic [7:0]        cur_byte;
    logic [7:0]        csum;
    logic              fire;
    logic              csum_add;
    logic [7:0]        payload [2*NCH];
    logic [PW-1:0]     pidx;

    // Payload bytes straight from the snapshot, zero-extended to 16 bits.
    generate
        for (genvar gi = 0; gi < NCH; gi++) begin : g_chan
            logic [15:0] chan_ext;
            assign chan_ext         = 16'(snap_reg[gi*DW +: DW]);
            assign payload[2*gi]    = chan_ext[15:8];
            assign payload[2*gi+1]  = chan_ext[7:0];
        end
    endgenerate

    assign fire     = (state_reg == ST_SEND) && link.tx_ready;
    // Only seq and payload bytes contribute to the checksum.
    assign csum_add = fire && (idx_reg != idx_t'(0)) && (idx_reg != LAST_IDX);
    assign pidx     = PW'(idx_reg - idx_t'(2));

    always_comb begin
        cur_byte = payload[pidx];
        if (idx_reg == idx_t'(0)) begin
            cur_byte = SYNC;
        end else if (idx_reg == idx_t'(1)) begin
            cur_byte = seq_reg;
        end else if (idx_reg == LAST_IDX) begin
            cur_byte = csum;
        end
    end

    // The sum restarts whenever the FSM is idle, so each frame begins clean.
    frame_checksum u_csum (
        .clk      (clk),
        .rst      (rst),
        .clear    (state_reg == ST_IDLE),
        .add_en   (csum_add),
        .add_byte (cur_byte),
        .sum      (csum)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= ST_IDLE;
            idx_reg     <= '0;
            gap_reg     <= 8'd0;
            seq_reg     <= 8'd0;
            snap_reg    <= '0;
            pending_reg <= 1'b0;
            overrun_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            idx_reg     <= idx_next;
            gap_reg     <= gap_next;
            seq_reg     <= seq_next;
            snap_reg    <= snap_next;
            pending_reg <= pending_next;
            overrun_reg <= overrun_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        idx_next     = idx_reg;
        gap_next     = gap_reg;
        seq_next     = seq_reg;
        snap_next    = snap_reg;
        pending_next = pending_reg;
        overrun_next = overrun_reg;

        case (state_reg)
            ST_IDLE: begin
                // start, a queued request and continuous mode all collapse
                // into one frame.
                if (link.start || pending_reg || link.continuous) begin
                    snap_next    = link.data_in;
                    pending_next = 1'b0;
                    idx_next     = '0;
                    state_next   = ST_SEND;
                end
            end
            ST_SEND: begin
                if (fire) begin
                    if (idx_reg == LAST_IDX) begin
                        seq_next   = seq_reg + 8'd1;
                        gap_next   = 8'd0;
                        state_next = (GAP == 0) ? ST_IDLE : ST_GAP;
                    end else begin
                        idx_next = idx_reg + idx_t'(1);
                    end
                end
            end
            ST_GAP: begin
                if (gap_reg == GAP_LAST) begin
                    state_next = ST_IDLE;
                end else begin
                    gap_next = gap_reg + 8'd1;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase

        // Requests while busy queue one deep; a second one is lost.
        if ((state_reg != ST_IDLE) && link.start) begin
            if (pending_reg) begin
                overrun_next = 1'b1;
            end else begin
                pending_next = 1'b1;
            end
        end
    end

    assign link.tx_valid = (state_reg == ST_SEND);
    assign link.tx_byte  = (state_reg == ST_SEND) ? cur_byte : 8'd0;
    assign link.busy     = (state_reg != ST_IDLE);
    assign link.seq      = seq_reg;
    assign link.overrun  = overrun_reg;

endmodule

// File: tb/tb_uart_frame_mux.sv
module tb_uart_frame_mux;
    import uart_frame_mux_pkg::*;

    localparam int NCH = 4;
    localparam int DW  = 12;
    localparam int GAP = 5;
    localparam int FL  = 11;
    localparam int NFR = 256;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    uart_frame_mux_if #(.NCH(NCH), .DW(DW)) link ();

    uart_frame_mux #(
        .NCH  (NCH),
        .DW   (DW),
        .SYNC (8'hA5),
        .GAP  (GAP)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .link (link)
    );

    int total = 0;
    int bad   = 0;
    int cyc_n = 0;

    logic [7:0] rx_b[$];
    int         rx_t[$];
    logic [7:0] exp_b [FL];
    logic [7:0] lit   [FL] = '{8'hA5, 8'h00, 8'h01, 8'h23, 8'h04, 8'h56,
                               8'h07, 8'h89, 8'h0A, 8'hBC, 8'hD4};

    localparam logic [47:0] D_BASIC = 48'hABC_789_456_123;
    localparam logic [47:0] D_SNAP  = 48'h00F_5A5_F00_0FF;
    localparam logic [47:0] D_OVR   = 48'hFFF_001_800_7E3;
    localparam logic [47:0] D_CONT  = 48'h3C4_B2A_691_F0E;

    // One clock: drive inputs at the falling edge, then record a byte if
    // valid and ready will both be present at the coming rising edge.
    task automatic cyc(input logic rdy, input logic st);
        @(negedge clk);
        cyc_n++;
        link.tx_ready = rdy;
        link.start    = st;
        if (link.tx_valid && rdy) begin
            rx_b.push_back(link.tx_byte);
            rx_t.push_back(cyc_n);
        end
    endtask

    task automatic clear_rx();
        rx_b.delete();
        rx_t.delete();
    endtask

    task automatic collect(input int n, input int budget, output bit ok);
        int c;
        c = 0;
        while (rx_b.size() < n && c < budget) begin
            cyc(1'b1, 1'b0);
            c++;
        end
        ok = (rx_b.size() >= n);
    endtask

    task automatic wait_idle();
        int c;
        c = 0;
        while (link.busy && c < 60) begin
            cyc(1'b1, 1'b0);
            c++;
        end
        total++;
        if (link.busy !== 1'b0) begin
            bad++;
            $display("FAIL wait_idle: busy=%b after %0d cycles, required 0", link.busy, c);
        end
    endtask

    // Reference frame from channel values and sequence number.
    task automatic build_exp(input logic [47:0] d, input logic [7:0] s);
        logic [15:0] w;
        logic [7:0]  sum;
        exp_b[0] = 8'hA5;
        exp_b[1] = s;
        sum      = s;
        for (int k = 0; k < NCH; k++) begin
            w = {4'h0, d[k*12 +: 12]};
            exp_b[2+2*k] = w[15:8];
            exp_b[3+2*k] = w[7:0];
            sum = sum + w[15:8] + w[7:0];
        end
        exp_b[FL-1] = sum;
    endtask

    task automatic test_reset();
        rst             = 1'b1;
        link.start      = 1'b0;
        link.continuous = 1'b0;
        link.tx_ready   = 1'b0;
        link.data_in    = '0;
        repeat (3) @(negedge clk);
        total += 5;
        if (link.tx_valid !== 1'b0) begin bad++; $display("FAIL reset_tx_valid: got %b want 0", link.tx_valid); end
        if (link.tx_byte !== 8'h00) begin bad++; $display("FAIL reset_tx_byte: got %h want 00", link.tx_byte); end
        if (link.busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", link.busy); end
        if (link.seq !== 8'h00) begin bad++; $display("FAIL reset_seq: got %h want 00", link.seq); end
        if (link.overrun !== 1'b0) begin bad++; $display("FAIL reset_overrun: got %b want 0", link.overrun); end
        rst = 1'b0;
        $display("reset: tx_valid=%b busy=%b seq=%h", link.tx_valid, link.busy, link.seq);
    endtask

    task automatic test_basic();
        bit ok;
        int t0;
        int first_bad;
        clear_rx();
        link.data_in = D_BASIC;
        cyc(1'b1, 1'b1);
        t0 = cyc_n;
        collect(FL, 40, ok);
        total++;
        if (!ok) begin bad++; $display("FAIL basic_timeout: got %0d bytes want %0d", rx_b.size(), FL); end
        for (int i = 0; i < FL && i < rx_b.size(); i++) begin
            total++;
            if (rx_b[i] !== lit[i]) begin
                bad++;
                $display("FAIL basic_byte%0d: got %h want %h", i, rx_b[i], lit[i]);
            end
        end
        first_bad = -1;
        for (int i = 0; i < rx_t.size(); i++)
            if (first_bad < 0 && rx_t[i] != t0 + 1 + i) first_bad = i;
        total++;
        if (first_bad >= 0) begin
            bad++;
            $display("FAIL basic_timing: byte %0d at cycle %0d want %0d", first_bad, rx_t[first_bad], t0 + 1 + first_bad);
        end
        cyc(1'b1, 1'b0);
        total += 3;
        if (link.tx_valid !== 1'b0) begin bad++; $display("FAIL basic_valid_drop: got %b want 0", link.tx_valid); end
        if (link.seq !== 8'h01) begin bad++; $display("FAIL basic_seq: got %h want 01", link.seq); end
        if (link.busy !== 1'b1) begin bad++; $display("FAIL basic_busy_gap: got %b want 1", link.busy); end
        $display("basic frame: %0d bytes, checksum %h", rx_b.size(), (rx_b.size() == FL) ? rx_b[FL-1] : 8'h00);
        wait_idle();
    endtask

    task automatic test_backpressure();
        logic [7:0] lfsr;
        logic       rdy, prev_v, prev_r;
        logic [7:0] prev_b;
        int c;
        clear_rx();
        build_exp(D_BASIC, 8'h01);
        lfsr   = 8'hB7;
        prev_v = 1'b0;
        prev_r = 1'b1;
        prev_b = 8'h00;
        cyc(1'b0, 1'b1);
        c = 0;
        while (rx_b.size() < FL && c < 200) begin
            lfsr = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
            rdy  = lfsr[0];
            cyc(rdy, 1'b0);
            if (prev_v && !prev_r) begin
                total++;
                if (link.tx_valid !== 1'b1 || link.tx_byte !== prev_b) begin
                    bad++;
                    $display("FAIL bp_stable: valid=%b byte=%h want valid=1 byte=%h", link.tx_valid, link.tx_byte, prev_b);
                end
            end
            prev_v = link.tx_valid;
            prev_b = link.tx_byte;
            prev_r = rdy;
            c++;
        end
        total++;
        if (rx_b.size() != FL) begin bad++; $display("FAIL bp_count: got %0d bytes want %0d", rx_b.size(), FL); end
        for (int i = 0; i < FL && i < rx_b.size(); i++) begin
            total++;
            if (rx_b[i] !== exp_b[i]) begin
                bad++;
                $display("FAIL bp_byte%0d: got %h want %h", i, rx_b[i], exp_b[i]);
            end
        end
        $display("backpressure frame: %0d bytes over %0d cycles", rx_b.size(), c);
        wait_idle();
    endtask

    task automatic test_snapshot();
        int c;
        clear_rx();
        build_exp(D_SNAP, 8'h02);
        link.data_in = D_SNAP;
        cyc(1'b1, 1'b1);
        c = 0;
        while (rx_b.size() < FL && c < 40) begin
            cyc(1'b1, 1'b0);
            link.data_in = {16'($urandom), $urandom};
            c++;
        end
        total++;
        if (rx_b.size() != FL) begin bad++; $display("FAIL snap_count: got %0d want %0d", rx_b.size(), FL); end
        for (int i = 0; i < FL && i < rx_b.size(); i++) begin
            total++;
            if (rx_b[i] !== exp_b[i]) begin
                bad++;
                $display("FAIL snap_byte%0d: got %h want %h", i, rx_b[i], exp_b[i]);
            end
        end
        $display("snapshot frame: %0d bytes, checksum %h", rx_b.size(), exp_b[FL-1]);
        wait_idle();
    endtask

    task automatic test_overrun();
        clear_rx();
        link.data_in = D_OVR;
        cyc(1'b1, 1'b1);
        for (int i = 1; i < 80; i++) begin
            cyc(1'b1, (i == 3) || (i == 5));
            if (i == 4) begin
                total++;
                if (link.overrun !== 1'b0) begin bad++; $display("FAIL ovr_first_pending: overrun=%b want 0", link.overrun); end
            end
            if (i == 6) begin
                total++;
                if (link.overrun !== 1'b1) begin bad++; $display("FAIL ovr_second: overrun=%b want 1", link.overrun); end
            end
        end
        build_exp(D_OVR, 8'h04);
        total += 3;
        if (rx_b.size() != 2 * FL) begin bad++; $display("FAIL ovr_frames: got %0d bytes want %0d", rx_b.size(), 2 * FL); end
        if (rx_b.size() >= 2 * FL) begin
            if (rx_b[FL] !== 8'hA5 || rx_b[FL+1] !== 8'h04 || rx_b[2*FL-1] !== exp_b[FL-1]) begin
                bad++;
                $display("FAIL ovr_frame2: sync=%h seq=%h csum=%h want A5 04 %h", rx_b[FL], rx_b[FL+1], rx_b[2*FL-1], exp_b[FL-1]);
            end
        end else begin
            bad++;
            $display("FAIL ovr_frame2: missing, got %0d bytes want %0d", rx_b.size(), 2 * FL);
        end
        if (link.overrun !== 1'b1) begin bad++; $display("FAIL ovr_sticky: overrun=%b want 1", link.overrun); end
        $display("overrun: %0d bytes, overrun=%b", rx_b.size(), link.overrun);
        wait_idle();
    endtask

    task automatic test_continuous();
        int c;
        int base;
        int nbad;
        logic [7:0] s;
        clear_rx();
        link.data_in    = D_CONT;
        link.continuous = 1'b1;
        c = 0;
        while (rx_b.size() < NFR * FL && c < NFR * 17 + 60) begin
            cyc(1'b1, 1'b0);
            c++;
        end
        link.continuous = 1'b0;
        repeat (40) cyc(1'b1, 1'b0);
        total++;
        if (rx_b.size() != NFR * FL) begin bad++; $display("FAIL cont_count: got %0d bytes want %0d", rx_b.size(), NFR * FL); end
        for (int k = 0; k < NFR && (k + 1) * FL <= rx_b.size(); k++) begin
            base = k * FL;
            s    = 8'(5 + k);
            build_exp(D_CONT, s);
            nbad = 0;
            for (int i = 0; i < FL; i++)
                if (rx_b[base+i] !== exp_b[i]) nbad++;
            total++;
            if (nbad != 0) begin
                bad++;
                $display("FAIL cont_frame%0d: seq=%h csum=%h want seq=%h csum=%h", k, rx_b[base+1], rx_b[base+FL-1], s, exp_b[FL-1]);
            end
            if (k > 0) begin
                total++;
                if (rx_t[base] - rx_t[base-FL] != 17) begin
                    bad++;
                    $display("FAIL cont_period%0d: got %0d want 17", k, rx_t[base] - rx_t[base-FL]);
                end
            end
            $display("cont frame %0d: seq=%h csum=%h at cycle %0d", k, rx_b[base+1], rx_b[base+FL-1], rx_t[base]);
        end
        total++;
        if (link.seq !== 8'h05) begin bad++; $display("FAIL cont_seq_wrap: got %h want 05", link.seq); end
        wait_idle();
    endtask

    task automatic test_reset_midframe();
        bit ok;
        clear_rx();
        link.data_in = D_SNAP;
        cyc(1'b1, 1'b1);
        collect(6, 30, ok);
        rst = 1'b1;
        #1;
        total += 5;
        if (!ok) begin bad++; $display("FAIL rst_mid_reach: got %0d bytes want 6", rx_b.size()); end
        if (link.tx_valid !== 1'b0) begin bad++; $display("FAIL rst_mid_valid: got %b want 0", link.tx_valid); end
        if (link.seq !== 8'h00) begin bad++; $display("FAIL rst_mid_seq: got %h want 00", link.seq); end
        if (link.busy !== 1'b0) begin bad++; $display("FAIL rst_mid_busy: got %b want 0", link.busy); end
        if (link.overrun !== 1'b0) begin bad++; $display("FAIL rst_mid_overrun: got %b want 0", link.overrun); end
        @(negedge clk);
        rst = 1'b0;
        clear_rx();
        build_exp(D_SNAP, 8'h00);
        cyc(1'b1, 1'b1);
        collect(FL, 40, ok);
        total++;
        if (!ok) begin bad++; $display("FAIL rst_refr_count: got %0d want %0d", rx_b.size(), FL); end
        for (int i = 0; i < FL && i < rx_b.size(); i++) begin
            total++;
            if (rx_b[i] !== exp_b[i]) begin
                bad++;
                $display("FAIL rst_refr_byte%0d: got %h want %h", i, rx_b[i], exp_b[i]);
            end
        end
        $display("post-reset frame: %0d bytes, sync=%h seq=%h", rx_b.size(),
                 (rx_b.size() > 0) ? rx_b[0] : 8'h00, (rx_b.size() > 1) ? rx_b[1] : 8'h00);
        wait_idle();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_snapshot();
        test_overrun();
        test_continuous();
        test_reset_midframe();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_frame_mux.md
# uart_frame_mux

Parametrised multi-channel frame serializer feeding the byte-level UART transmitter in the inter-board game link. Snapshots NCH game-state fields of DW bits each, then emits them as one framed packet: sync byte, sequence number, 2 bytes per channel, additive checksum. Supports one-shot and continuous modes, with a one-deep pending request and a programmable inter-frame gap. Generalises the fixed two-field link multiplexer so that both boards can exchange player, ball, score and flag state over one format.

## Interface
- NCH, 4: number of channels, 1..16
- DW, 12: channel width, 1..16 bits; zero-extended to 16 on the wire
- SYNC, 8'hA5: frame start byte
- GAP, 0: idle cycles forced between consecutive frames, 0..255
- clk  in  1  system clock; all logic on its rising edge
- rst  in  1  asynchronous, active-high reset
- data_in  in  NCH*DW  channel k occupies bits [k*DW +: DW]
- start  in  1  single-cycle frame request
- continuous  in  1  when high, a new frame starts automatically after each frame plus GAP
- tx_ready  in  1  byte transmitter can accept a byte
- tx_valid  out  1  tx_byte is valid
- tx_byte  out  8  byte offered to the transmitter
- busy  out  1  frame in progress or in gap
- seq  out  8  sequence number of the next frame
- overrun  out  1  sticky; set when start arrives while busy and a request is already pending

## Operation
- Reset values: tx_valid=0, tx_byte=0, busy=0, seq=0, overrun=0, pending=0, state=IDLE.
- Frame layout, FL=3+2*NCH bytes: SYNC, seq, then for k=0..NCH-1 the high byte and low byte of zero-extended channel k, then checksum.
- Checksum: 8-bit sum mod 256 of every byte after SYNC and before the checksum byte.
- States:
  - IDLE: on a trigger (start, pending, or continuous), latch data_in into a snapshot register, clear pending, set byte index 0 and go to SEND.
  - SEND: assert tx_valid with the current byte. On tx_valid&&tx_ready, advance the index and accumulate the checksum. After the checksum byte transfers, increment seq (255 wraps to 0) and go to GAP, or to IDLE if GAP=0.
  - GAP: count GAP cycles with tx_valid low, then go to IDLE.
- Handshake: tx_byte stays stable while tx_valid=1 and tx_ready=0. tx_valid never drops before a transfer.
- Snapshot isolation: changes to data_in during SEND or GAP do not affect the current frame.
- start while busy: sets pending. If pending is already set, the request is dropped and overrun is set. Only reset clears overrun.
- continuous=1 with pending=1: a single frame satisfies both.
- continuous deasserted mid-frame: the current frame completes and no further automatic frame follows.
- Reset asserted mid-frame: outputs return to reset values immediately. The partial frame is abandoned; the receiver resynchronises on SYNC.

## Timing
- start high in cycle 0 (state IDLE, GAP idle): snapshot taken at the cycle-0 edge. tx_valid=1 with tx_byte=SYNC from cycle 1.
- With tx_ready held high, one byte transfers per cycle. A frame occupies FL cycles, and tx_valid drops in cycle FL+1.
- busy is high from cycle 1 until the last GAP cycle inclusive.
- Continuous mode with tx_ready always high: frame period is FL+GAP+1 cycles (one IDLE cycle between frames).

## Structure
- A shared link package holds SYNC, the frame-length function (3+2*NCH), and the state encoding. The receive-side demultiplexer imports the same package.
- One sub-module, frame_checksum: an 8-bit accumulator with clear and add-enable.
- Everything else is a single FSM with byte-index and gap counters. The index counter is $clog2(FL) bits wide.

## Test plan
- NCH=4, DW=12, data {ch0..3}={12'h123,12'h456,12'h789,12'hABC}, start, tx_ready=1 -> bytes A5,00,01,23,04,56,07,89,0A,BC,D4 on consecutive cycles; seq becomes 1.
- Same frame with tx_ready toggling pseudo-randomly -> identical byte sequence, and tx_byte stable whenever tx_valid&&!tx_ready.
- data_in changed every cycle during the frame -> emitted payload equals the cycle-0 snapshot.
- Two starts during a frame, then a third -> exactly one extra frame follows and overrun=1.
- continuous=1, GAP=5, 256 frames -> period of 17 cycles with NCH=4; seq wraps 255->0, and the checksum is correct in every frame.
- rst asserted at byte 6 -> tx_valid=0 and seq=0 at once; the next start emits a full frame beginning with A5,00.
